// File: rtl/risc_exec_sequencer.sv
// Multicycle control sequencer for the RISC datapath: accepts one instruction per
// start/ready handshake and steps register reads, ALU strobes and writeback.
module risc_exec_sequencer #(
   parameter int WIDTH = 16,
   parameter int RSEL  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s,
   input  logic [15:0]      instr,
   output logic             w,
   output logic             err,
   output logic [RSEL-1:0]  rd_addr,
   output logic [RSEL-1:0]  wr_addr,
   output logic             write,
   output logic             loada,
   output logic             loadb,
   output logic             loadc,
   output logic             loads,
   output logic             asel,
   output logic             bsel,
   output logic [1:0]       vsel,
   output logic [WIDTH-1:0] sximm8,
   output logic             addSubVals,
   output logic             andVals,
   output logic             notBVal,
   output logic             sub
);

   typedef enum logic [2:0] {
      WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_REG, WRITE_IMM
   } state_t;

   typedef struct packed {
      logic            w;
      logic            err;
      logic [RSEL-1:0] rd_addr;
      logic [RSEL-1:0] wr_addr;
      logic            write;
      logic            loada;
      logic            loadb;
      logic            loadc;
      logic            loads;
      logic            asel;
      logic            bsel;
      logic [1:0]      vsel;
      logic            add_sub;
      logic            and_vals;
      logic            not_b;
      logic            sub;
   } ctrl_t;

   state_t      state, state_nxt;
   logic [15:0] ir, ir_nxt;
   ctrl_t       ctrl, ctrl_nxt;

   logic [2:0] opc, opc_nxt;
   logic [1:0] op, op_nxt;
   logic       is_mov_imm, is_mov_reg, is_alu, legal;

   assign opc        = ir[15:13];
   assign op         = ir[12:11];
   assign opc_nxt    = ir_nxt[15:13];
   assign op_nxt     = ir_nxt[12:11];
   assign is_mov_imm = (opc == 3'b110) && (op == 2'b10);
   assign is_mov_reg = (opc == 3'b110) && (op == 2'b00);
   assign is_alu     = (opc == 3'b101);
   assign legal      = is_mov_imm || is_mov_reg || is_alu;

   always_comb begin
      state_nxt = state;
      ir_nxt    = ir;
      case (state)
         WAIT: begin
            if (s) begin
               ir_nxt    = instr;
               state_nxt = DECODE;
            end
         end
         DECODE: begin
            if (is_mov_imm)
               state_nxt = WRITE_IMM;
            else if (is_alu && (op != 2'b11))
               state_nxt = GET_A;
            else if (is_mov_reg || is_alu)
               state_nxt = GET_B;
            else
               state_nxt = WAIT;
         end
         GET_A:     state_nxt = GET_B;
         GET_B:     state_nxt = EXEC;
         EXEC:      state_nxt = (is_alu && (op == 2'b01)) ? WAIT : WRITE_REG;
         WRITE_REG: state_nxt = WAIT;
         WRITE_IMM: state_nxt = WAIT;
         default:   state_nxt = WAIT;
      endcase
   end

   // Outputs are precomputed for the state being entered so they appear registered.
   always_comb begin
      ctrl_nxt = '0;
      case (state_nxt)
         WAIT:   ctrl_nxt.w = 1'b1;
         DECODE: ctrl_nxt.err = !(((opc_nxt == 3'b110) && ((op_nxt == 2'b10) || (op_nxt == 2'b00)))
                                  || (opc_nxt == 3'b101));
         GET_A: begin
            ctrl_nxt.rd_addr = RSEL'(ir_nxt[10:8]);
            ctrl_nxt.loada   = 1'b1;
         end
         GET_B: begin
            ctrl_nxt.rd_addr = RSEL'(ir_nxt[2:0]);
            ctrl_nxt.loadb   = 1'b1;
         end
         EXEC: begin
            if (opc_nxt == 3'b110) begin
               ctrl_nxt.add_sub = 1'b1;
               ctrl_nxt.asel    = 1'b1;
               ctrl_nxt.loadc   = 1'b1;
            end else begin
               case (op_nxt)
                  2'b00: begin
                     ctrl_nxt.add_sub = 1'b1;
                     ctrl_nxt.loadc   = 1'b1;
                  end
                  2'b01: begin
                     ctrl_nxt.add_sub = 1'b1;
                     ctrl_nxt.sub     = 1'b1;
                     ctrl_nxt.loads   = 1'b1;
                  end
                  2'b10: begin
                     ctrl_nxt.and_vals = 1'b1;
                     ctrl_nxt.loadc    = 1'b1;
                  end
                  default: begin
                     ctrl_nxt.not_b = 1'b1;
                     ctrl_nxt.loadc = 1'b1;
                  end
               endcase
            end
         end
         WRITE_REG: begin
            ctrl_nxt.write   = 1'b1;
            ctrl_nxt.wr_addr = RSEL'(ir_nxt[7:5]);
         end
         WRITE_IMM: begin
            ctrl_nxt.write   = 1'b1;
            ctrl_nxt.wr_addr = RSEL'(ir_nxt[10:8]);
            ctrl_nxt.vsel    = 2'b10;
         end
         default: ctrl_nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= WAIT;
         ir     <= '0;
         ctrl   <= '0;
         ctrl.w <= 1'b1;
      end else begin
         state <= state_nxt;
         ir    <= ir_nxt;
         ctrl  <= ctrl_nxt;
      end
   end

   assign w          = ctrl.w;
   assign err        = ctrl.err;
   assign rd_addr    = ctrl.rd_addr;
   assign wr_addr    = ctrl.wr_addr;
   assign write      = ctrl.write;
   assign loada      = ctrl.loada;
   assign loadb      = ctrl.loadb;
   assign loadc      = ctrl.loadc;
   assign loads      = ctrl.loads;
   assign asel       = ctrl.asel;
   assign bsel       = ctrl.bsel;
   assign vsel       = ctrl.vsel;
   assign addSubVals = ctrl.add_sub;
   assign andVals    = ctrl.and_vals;
   assign notBVal    = ctrl.not_b;
   assign sub        = ctrl.sub;
   assign sximm8     = WIDTH'($signed(ir[7:0]));

   // DECODE only ever sees legal/illegal through ctrl_nxt.err; keep the flag observable.
   logic unused_legal;
   assign unused_legal = legal;

endmodule

// File: tb/tb_risc_exec_sequencer.sv
// Self-checking bench for risc_exec_sequencer: per-instruction expected output
// sequences built from the ISA rules, checked every cycle, plus directed pins.
module tb_risc_exec_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s;
   logic [15:0] instr;
   logic        w, err, write, loada, loadb, loadc, loads, asel, bsel;
   logic [2:0]  rd_addr, wr_addr;
   logic [1:0]  vsel;
   logic [15:0] sximm8;
   logic        addSubVals, andVals, notBVal, sub;

   int tests = 0;
   int fails = 0;
   bit check_en = 1'b0;

   risc_exec_sequencer #(.WIDTH(16), .RSEL(3)) dut (
      .clk(clk), .rst_n(rst_n), .s(s), .instr(instr),
      .w(w), .err(err), .rd_addr(rd_addr), .wr_addr(wr_addr), .write(write),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
      .asel(asel), .bsel(bsel), .vsel(vsel), .sximm8(sximm8),
      .addSubVals(addSubVals), .andVals(andVals), .notBVal(notBVal), .sub(sub)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       w, err;
      logic [2:0] rd_addr, wr_addr;
      logic       write, loada, loadb, loadc, loads, asel, bsel;
      logic [1:0] vsel;
      logic       add, andv, notb, sub;
   } out_t;

   out_t        exp_q[$];
   logic [15:0] m_ir = 16'h0;

   function automatic out_t idleOut();
      out_t o;
      o = '0;
      o.w = 1'b1;
      return o;
   endfunction

   // One entry per cycle the instruction occupies, starting with its decode cycle.
   task automatic buildSeq(input logic [15:0] v);
      out_t o;
      logic [2:0] opc;
      logic [1:0] op;
      bit mov_imm, mov_reg, alu;
      opc = v[15:13];
      op  = v[12:11];
      mov_imm = (opc == 3'b110) && (op == 2'b10);
      mov_reg = (opc == 3'b110) && (op == 2'b00);
      alu     = (opc == 3'b101);
      o = '0;
      o.err = !(mov_imm || mov_reg || alu);
      exp_q.push_back(o);
      if (mov_imm) begin
         o = '0; o.write = 1; o.wr_addr = v[10:8]; o.vsel = 2'b10;
         exp_q.push_back(o);
      end else if (mov_reg || alu) begin
         if (alu && op != 2'b11) begin
            o = '0; o.rd_addr = v[10:8]; o.loada = 1;
            exp_q.push_back(o);
         end
         o = '0; o.rd_addr = v[2:0]; o.loadb = 1;
         exp_q.push_back(o);
         o = '0;
         if (mov_reg) begin o.add = 1; o.asel = 1; o.loadc = 1; end
         else if (op == 2'b00) begin o.add = 1; o.loadc = 1; end
         else if (op == 2'b01) begin o.add = 1; o.sub = 1; o.loads = 1; end
         else if (op == 2'b10) begin o.andv = 1; o.loadc = 1; end
         else begin o.notb = 1; o.loadc = 1; end
         exp_q.push_back(o);
         if (!(alu && op == 2'b01)) begin
            o = '0; o.write = 1; o.wr_addr = v[7:5];
            exp_q.push_back(o);
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         m_ir = 16'h0;
      end else if (exp_q.size() == 0) begin
         if (s) begin
            m_ir = instr;
            buildSeq(instr);
         end
      end else begin
         void'(exp_q.pop_front());
      end
   end

   always @(negedge clk) begin
      out_t a, e;
      logic [15:0] ex;
      if (check_en) begin
         e = (exp_q.size() != 0) ? exp_q[0] : idleOut();
         a = {w, err, rd_addr, wr_addr, write, loada, loadb, loadc, loads, asel, bsel,
              vsel, addSubVals, andVals, notBVal, sub};
         tests++;
         if (a !== e) begin
            fails++;
            $display("[TB] FAIL cycle_outputs t=%0t actual=%h expected=%h", $time, a, e);
         end
         ex = {{8{m_ir[7]}}, m_ir[7:0]};
         tests++;
         if (sximm8 !== ex) begin
            fails++;
            $display("[TB] FAIL cycle_sximm8 t=%0t actual=%h expected=%h", $time, sximm8, ex);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] v, input bit hold, input logic [15:0] nextv);
      @(negedge clk);
      s = 1'b1;
      instr = v;
      @(posedge clk);
      #1;
      instr = nextv;
      if (!hold) s = 1'b0;
   endtask

   task automatic waitIdle();
      int k;
      s = 1'b0;
      for (k = 0; k < 20; k++) begin
         if (w) break;
         @(posedge clk);
         #1;
      end
      checkOutput("wait_idle_timeout", {31'b0, w}, 32'h1);
   endtask

   // mask bits: loada loadb loadc loads asel add and not sub write err
   task automatic runDirected(input string name, input logic [15:0] v, input bit hold,
                              input logic [15:0] nextv, input int exp_lat,
                              input logic [10:0] exp_mask, input logic [2:0] exp_rda,
                              input logic [2:0] exp_rdb, input logic [2:0] exp_wr,
                              input logic [1:0] exp_vsel, output logic [15:0] imm_seen);
      int lat, errs;
      logic [10:0] mask;
      logic [2:0] rda, rdb, wra;
      logic [1:0] vs;
      applyStimulus(v, hold, nextv);
      lat = 1; errs = 0; mask = '0; rda = 0; rdb = 0; wra = 0; vs = 0; imm_seen = 0;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
            lat++;
         end
         mask |= {loada, loadb, loadc, loads, asel, addSubVals, andVals, notBVal, sub, write, err};
         if (err) errs++;
         if (loada) rda = rd_addr;
         if (loadb) rdb = rd_addr;
         if (write) begin
            wra = wr_addr;
            vs = vsel;
            imm_seen = sximm8;
         end
         if (k > 0 && w) break;
      end
      checkOutput({name, "_latency"}, lat, exp_lat);
      checkOutput({name, "_strobes"}, {21'b0, mask}, {21'b0, exp_mask});
      checkOutput({name, "_err_cycles"}, errs, {31'b0, exp_mask[0]});
      if (exp_mask[10]) checkOutput({name, "_rd_a"}, {29'b0, rda}, {29'b0, exp_rda});
      if (exp_mask[9])  checkOutput({name, "_rd_b"}, {29'b0, rdb}, {29'b0, exp_rdb});
      if (exp_mask[1]) begin
         checkOutput({name, "_wr_addr"}, {29'b0, wra}, {29'b0, exp_wr});
         checkOutput({name, "_vsel"}, {30'b0, vs}, {30'b0, exp_vsel});
      end
   endtask

   initial begin
      logic [15:0] imm;
      bit wrote;
      rst_n = 1'b1;
      s = 1'b0;
      instr = 16'h0;
      #2 rst_n = 1'b0;
      #10;
      checkOutput("reset_w", {31'b0, w}, 32'h1);
      checkOutput("reset_err_write", {30'b0, err, write}, 32'h0);
      checkOutput("reset_sximm8", {16'b0, sximm8}, 32'h0);
      check_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // Reset in the middle of an ADD must abandon it without any writeback.
      applyStimulus(16'hA140, 1'b0, 16'h1234);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("rst_pre_loadb", {31'b0, loadb}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_async_w", {31'b0, w}, 32'h1);
      checkOutput("rst_async_loadb_write", {30'b0, loadb, write}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      wrote = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (write) wrote = 1'b1;
      end
      checkOutput("rst_no_write", {31'b0, wrote}, 32'h0);

      runDirected("mov_imm", 16'hD3FE, 1'b0, 16'h0, 3, 11'b00000000010, 0, 0, 3'd3, 2'b10, imm);
      checkOutput("mov_imm_sximm8", {16'b0, imm}, 32'hFFFE);
      runDirected("add", 16'hA140, 1'b0, 16'hFFFF, 6, 11'b11100100010, 3'd1, 3'd0, 3'd2, 2'b00, imm);
      runDirected("cmp", 16'hAD06, 1'b0, 16'h0, 5, 11'b11010100100, 3'd5, 3'd6, 3'd0, 2'b00, imm);
      runDirected("mvn", 16'hB8E4, 1'b0, 16'h0, 5, 11'b01100001010, 3'd0, 3'd4, 3'd7, 2'b00, imm);
      runDirected("mov_reg", 16'hC022, 1'b0, 16'h0, 5, 11'b01101100010, 3'd0, 3'd2, 3'd1, 2'b00, imm);
      runDirected("illegal", 16'h0000, 1'b1, 16'hA140, 2, 11'b00000000001, 0, 0, 0, 2'b00, imm);
      @(posedge clk); #1;
      checkOutput("b2b_reaccept_w", {31'b0, w}, 32'h0);
      waitIdle();

      for (int n = 0; n < 600; n++) begin
         logic [15:0] r;
         @(negedge clk);
         r = 16'($urandom);
         case ($urandom_range(0, 3))
            1: r[15:13] = 3'b101;
            2: r[15:13] = 3'b110;
            default: ;
         endcase
         instr = r;
         s = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 99) == 0) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end
      waitIdle();
      repeat (2) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/risc_exec_sequencer.md
Name: risc_exec_sequencer

Overview:
- Multicycle control FSM that sequences the RISC datapath (register file, A/B/C pipeline registers, ALU operation unit, status register) for one instruction at a time.
- Accepts a 16-bit instruction via a start/ready handshake and decodes it.
- Drives register selects, load enables, operand muxes and the ALU strobes (addSubVals/andVals/notBVal/sub) cycle by cycle until writeback completes.

Parameters:
WIDTH, 16, datapath width; the sign-extended immediate is this wide (must be >= 8)
RSEL, 3, register-address width (8 registers)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
s  input  1  start request; sampled only while w=1
instr  input  16  instruction word; captured into internal IR on accept
w  output  1  ready/idle (high only in WAIT)
err  output  1  illegal-instruction flag; high for the single DECODE cycle of an illegal instruction
rd_addr  output  RSEL  register-file read address
wr_addr  output  RSEL  register-file write address
write  output  1  register-file write enable
loada  output  1  load A register
loadb  output  1  load B register
loadc  output  1  load C register
loads  output  1  load status register (Z/N/V)
asel  output  1  1 = ALU A input forced to zero
bsel  output  1  1 = ALU B input from immediate (always 0 in this block)
vsel  output  2  writeback source: 00 = C, 10 = sximm8; 01/11 never driven
sximm8  output  WIDTH  IR[7:0] sign-extended to WIDTH, driven continuously from IR
addSubVals  output  1  ALU add/sub enable
andVals  output  1  ALU AND enable
notBVal  output  1  ALU NOT-B enable
sub  output  1  subtract select

Behaviour:
- Instruction fields:
  - opc = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], Rm = IR[2:0].
  - Legal: opc=110/op=10 MOV Rn,#imm8; opc=110/op=00 MOV Rd,Rm; opc=101 with op 00 ADD, 01 CMP, 10 AND, 11 MVN.
  - Everything else is illegal.
- States: WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_REG, WRITE_IMM. Moore outputs decoded from state and IR.
- Outputs are 0 in every state unless listed below.
- Reset:
  - rst_n low asynchronously forces WAIT and IR=0, at any time, including mid-instruction.
  - Outputs immediately take WAIT values: w=1, all others 0, sximm8=0.
  - No partial writeback completes after reset asserts.
- Handshake:
  - In WAIT, s=1 at a rising edge captures instr into IR and moves the FSM to DECODE.
  - s is ignored outside WAIT. instr may change freely after accept.
  - Back-to-back: s held high in WAIT re-accepts on the first edge after w returns to 1.
- Transitions from DECODE:
  - MOV imm -> WRITE_IMM.
  - ADD/CMP/AND -> GET_A.
  - MOV reg/MVN -> GET_B.
  - Illegal -> WAIT, with err=1 during DECODE.
- Later transitions:
  - GET_A -> GET_B -> EXEC.
  - EXEC -> WAIT for CMP; otherwise EXEC -> WRITE_REG.
  - WRITE_REG -> WAIT; WRITE_IMM -> WAIT.
- State outputs:
  - GET_A: rd_addr=Rn, loada=1.
  - GET_B: rd_addr=Rm, loadb=1.
  - EXEC: bsel=0; exactly one of addSubVals/andVals/notBVal high, per the EXEC strobe rules below.
  - WRITE_REG: write=1, wr_addr=Rd, vsel=00.
  - WRITE_IMM: write=1, wr_addr=Rn, vsel=10.
- EXEC strobes:
  - ADD: addSubVals=1, loadc=1.
  - CMP: addSubVals=1, sub=1, loads=1, loadc=0.
  - AND: andVals=1, loadc=1.
  - MVN: notBVal=1, loadc=1.
  - MOV reg: addSubVals=1, asel=1, loadc=1 (computes 0+B).
- rd_addr/wr_addr are 0 outside their states; write is never high outside the two write states.
- Latency (edges from the accept edge until w=1 again, accept edge counted): MOV imm 3; ADD/AND 6; CMP 5; MOV reg/MVN 5; illegal 2.
- sximm8 = {{(WIDTH-8){IR[7]}}, IR[7:0]}.

Test Plan:
- Reset mid-op: accept ADD, pull rst_n low during GET_B -> immediately w=1, loadb=0, write=0; after release, no write ever occurs for that instruction.
- MOV R3,#-2 (instr 16'hD3FE), WIDTH=16 -> w high on edge 3; in WRITE_IMM write=1, wr_addr=3, vsel=10, sximm8=16'hFFFE.
- ADD R2,R1,R0 (16'hA140) -> GET_A rd_addr=1 loada=1; GET_B rd_addr=0 loadb=1; EXEC addSubVals=1 sub=0 loadc=1; WRITE_REG wr_addr=2 write=1; w=1 after 6 edges.
- CMP R5,R6 (16'hAD06) -> EXEC addSubVals=1 sub=1 loads=1 loadc=0; write never high; w=1 after 5 edges.
- MVN R7,R4 (16'hB8E4) and MOV R1,R2 (16'hC022) -> skip GET_A (loada never 1); EXEC notBVal=1 for MVN, asel=1 with addSubVals=1 for MOV; writes to R7 and R1 respectively.
- Illegal 16'h0000 with s held high -> err=1 for exactly one cycle, w=1 after 2 edges; s remains high, so the next instr is accepted on the following edge.
